// File: rtl/alu_seq.sv
// alu_seq: buffers ALU commands in a FIFO and sequences them through an external combinational ALU into an accumulator.
// Latency: push into an empty FIFO -> ALU pins driven after 1 edge -> res_valid after 2 edges; one result per 3 cycles.
// Backpressure: res_ready low holds res_data and stops popping; cmd_ready is low only while the FIFO is full.
//
// Optional build macro: ALU_SEQ_ILLEGAL_OP_EN. When defined, a non-load command with sel > OP_MAX
// skips the ALU and returns the unchanged accumulator with res_err set. Otherwise res_err stays 0.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                command handshake; cmd_sel, cmd_operand, cmd_load payload
//   alu_a, alu_b, alu_sel              registered drive toward the ALU; alu_result returns its output
//   res_valid/res_ready                result handshake; res_data value, res_err illegal-op flag
//   acc                                current accumulator
//   busy                               FIFO non-empty or sequencer not idle
module alu_seq #(
    parameter int WIDTH      = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int OP_MAX     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_sel,
    input  logic [WIDTH-1:0] cmd_operand,
    input  logic             cmd_load,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic [WIDTH-1:0] acc,
    output logic             busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [2:0]  SEL_MAX = 3'(OP_MAX);

`ifdef ALU_SEQ_ILLEGAL_OP_EN
    localparam bit CHK_ILLEGAL = 1'b1;
`else
    localparam bit CHK_ILLEGAL = 1'b0;
`endif

    typedef struct packed {
        logic             load;
        logic [2:0]       sel;
        logic [WIDTH-1:0] operand;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

    // ---------------- command FIFO ----------------
    cmd_t        mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        rdy_en_q;      // keeps cmd_ready low until the first edge after reset release
    logic        empty, full, push, pop;
    cmd_t        head, cmd_in;

    assign cmd_in    = '{load: cmd_load, sel: cmd_sel, operand: cmd_operand};
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Built from registers only, so a pop in the same cycle never frees a slot early.
    assign cmd_ready = rdy_en_q && !full;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= cmd_in;
    end

    // ---------------- sequencer ----------------
    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]       alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_valid_q, res_valid_d;
    logic             res_err_q, res_err_d;
    logic             head_illegal;

    // Folds to 0 when the illegal-op check is not built in.
    assign head_illegal = CHK_ILLEGAL && (head.sel > SEL_MAX);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        res_err_d   = res_err_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !res_valid_q) begin
                    pop = 1'b1;
                    if (head.load) begin
                        // Load bypasses the ALU and reports the new value at once.
                        acc_d       = head.operand;
                        res_data_d  = head.operand;
                        res_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else if (head_illegal) begin
                        res_data_d  = acc_q;
                        res_err_d   = 1'b1;
                        res_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        alu_a_d   = acc_q;
                        alu_b_d   = head.operand;
                        alu_sel_d = head.sel;
                        state_d   = DRIVE;
                    end
                end
            end
            DRIVE: begin
                // ALU pins have been stable for a full cycle; take its answer.
                acc_d       = alu_result;
                res_data_d  = alu_result;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    res_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            res_err_q   <= res_err_d;
        end
    end

    assign acc       = acc_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign res_err   = res_err_q;
    assign busy      = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: drives alu_seq against a stub ALU (sel 000 -> A+B mod 16, else A^B).
// Expected results are queued when a command is pushed and compared when the result handshakes.
module tb_alu_seq;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         cmd_valid = 1'b0, cmd_load = 1'b0, res_ready = 1'b1;
    logic [2:0]   cmd_sel = '0;
    logic [W-1:0] cmd_operand = '0;
    logic         cmd_ready, res_valid, res_err, busy;
    logic [W-1:0] alu_a, alu_b, alu_result, res_data, acc;
    logic [2:0]   alu_sel;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    typedef struct {
        logic         load;
        logic [2:0]   sel;
        logic [W-1:0] op;
        logic [W-1:0] exp_data;
        logic         exp_err;
    } vec_t;
    vec_t tbl[6];

    always #5 clk = ~clk;

    assign alu_result = (alu_sel == 3'b000) ? W'(alu_a + alu_b) : (alu_a ^ alu_b);

    alu_seq #(.WIDTH(W), .FIFO_DEPTH(4), .OP_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_operand(cmd_operand), .cmd_load(cmd_load),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .acc(acc), .busy(busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Scoreboard: every accepted result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got data %0d, expected no result", res_data);
            end else begin
                mon_e = sb_q.pop_front();
                chk("res_data", int'(res_data), int'(mon_e.data));
                chk("res_err", int'(res_err), int'(mon_e.err));
            end
        end
    end

    // One command, offered just after a rising edge and held until accepted.
    task automatic push(input logic ld, input logic [2:0] s, input logic [W-1:0] op,
                        input logic [W-1:0] ed, input logic ee, input bit track);
        int  n = 0;
        bit  done = 0;
        exp_t e;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_load = ld; cmd_sel = s; cmd_operand = op;
        while (!done && n < 100) begin
            @(negedge clk);
            if (cmd_ready) begin
                if (track) begin
                    e.data = ed;
                    e.err  = ee;
                    sb_q.push_back(e);
                end
                @(posedge clk);
                done = 1;
            end
            n++;
        end
        if (!done) timeout("push");
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        bit ok = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = !busy && !res_valid;
            n++;
        end
        if (!ok) timeout("wait_idle");
    endtask

    // Measures the idle gap between consecutive results during a streaming run.
    task automatic sample_tput(input int nres);
        int seen = 0, gap = 0, cyc = 0;
        while (seen < nres && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (res_valid) begin
                if (seen > 0) chk("tput_gap", gap, 2);
                seen++;
                gap = 0;
            end else begin
                gap++;
            end
        end
        if (seen < nres) timeout("tput");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming vectors, starting from acc = 4.
        tbl[0] = '{1'b0, 3'd0, 4'd5,  4'd9,  1'b0};
        tbl[1] = '{1'b0, 3'd1, 4'd3,  4'd10, 1'b0};
        tbl[2] = '{1'b0, 3'd2, 4'd15, 4'd5,  1'b0};
        tbl[3] = '{1'b0, 3'd0, 4'd12, 4'd1,  1'b0};
        tbl[4] = '{1'b0, 3'd4, 4'd1,  4'd0,  1'b0};
        tbl[5] = '{1'b0, 3'd3, 4'd6,  4'd6,  1'b0};

        // ---- reset state ----
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_acc", int'(acc), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_res_err", int'(res_err), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_sel", int'(alu_sel), 0);
        #2 rst_n = 1'b1;
        #1 chk("rdy_before_edge", int'(cmd_ready), 0);
        @(posedge clk); @(negedge clk);
        chk("rdy_after_release", int'(cmd_ready), 1);

        // ---- load then add, with ALU pin and latency checks ----
        push(1'b1, 3'd0, 4'd3, 4'd3, 1'b0, 1);
        wait_idle();
        chk("acc_after_load", int'(acc), 3);
        push(1'b0, 3'd0, 4'd1, 4'd4, 1'b0, 1);
        @(posedge clk); @(negedge clk);
        chk("drive_alu_a", int'(alu_a), 3);
        chk("drive_alu_b", int'(alu_b), 1);
        chk("drive_alu_sel", int'(alu_sel), 0);
        chk("drive_res_valid", int'(res_valid), 0);
        @(negedge clk);
        chk("latency_res_valid", int'(res_valid), 1);
        wait_idle();
        chk("acc_after_add", int'(acc), 4);

        // ---- streaming table with res_ready held high ----
        fork
            for (int i = 0; i < 6; i++)
                push(tbl[i].load, tbl[i].sel, tbl[i].op, tbl[i].exp_data, tbl[i].exp_err, 1);
            sample_tput(6);
        join
        wait_idle();
        chk("acc_after_table", int'(acc), 6);

        // ---- backpressure: one held result plus a full FIFO ----
        res_ready = 1'b0;
        push(1'b1, 3'd0, 4'd2,  4'd2, 1'b0, 1);
        push(1'b0, 3'd0, 4'd3,  4'd5, 1'b0, 1);
        push(1'b0, 3'd1, 4'd7,  4'd2, 1'b0, 1);
        push(1'b0, 3'd0, 4'd15, 4'd1, 1'b0, 1);
        push(1'b1, 3'd0, 4'd9,  4'd9, 1'b0, 1);
        @(negedge clk);
        chk("full_cmd_ready", int'(cmd_ready), 0);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_sel = 3'd0; cmd_operand = 4'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("refused_cmd_ready", int'(cmd_ready), 0);
            chk("held_res_data", int'(res_data), 2);
            chk("held_res_valid", int'(res_valid), 1);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        wait_idle();
        chk("acc_after_drain", int'(acc), 9);
        chk("drain_queue_empty", sb_q.size(), 0);

        // ---- wrap-around add ----
        push(1'b1, 3'd0, 4'd15, 4'd15, 1'b0, 1);
        push(1'b0, 3'd0, 4'd2,  4'd1,  1'b0, 1);
        wait_idle();
        chk("acc_after_wrap", int'(acc), 1);

        // ---- illegal sel ----
        push(1'b1, 3'd0, 4'd5, 4'd5, 1'b0, 1);
`ifdef ALU_SEQ_ILLEGAL_OP_EN
        push(1'b0, 3'd7, 4'd3, 4'd5, 1'b1, 1);
        wait_idle();
        chk("illegal_acc", int'(acc), 5);
        chk("illegal_alu_sel", int'(alu_sel), 0);
        chk("illegal_alu_b", int'(alu_b), 2);
`else
        push(1'b0, 3'd7, 4'd3, 4'd6, 1'b0, 1);
        wait_idle();
        chk("sel7_acc", int'(acc), 6);
        chk("sel7_alu_sel", int'(alu_sel), 7);
        chk("sel7_alu_b", int'(alu_b), 3);
`endif

        // ---- reset during DRIVE with two commands queued ----
        res_ready = 1'b0;
        push(1'b1, 3'd0, 4'd10, 4'd10, 1'b0, 1);
        push(1'b0, 3'd0, 4'd1,  4'd0,  1'b0, 0);
        push(1'b0, 3'd1, 4'd4,  4'd0,  1'b0, 0);
        push(1'b0, 3'd0, 4'd7,  4'd0,  1'b0, 0);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("pre_rst_alu_a", int'(alu_a), 10);
        chk("pre_rst_alu_b", int'(alu_b), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_res_valid", int'(res_valid), 0);
        chk("midrst_acc", int'(acc), 0);
        chk("midrst_alu_a", int'(alu_a), 0);
        chk("midrst_cmd_ready", int'(cmd_ready), 0);
        #3 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_acc", int'(acc), 0);
        chk("final_queue_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
